delay_prog: RTL and testbench

//  Runtime-programmable, multi-channel, valid-qualified delay line for DSP streams.

---
 rtl/delay_prog_pkg.sv | 17 +
 rtl/delay_prog_bram_sdp.sv | 33 +++
 rtl/delay_prog.sv | 107 ++++++++++
 tb/tb_delay_prog.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/delay_prog_pkg.sv
// Shared definitions for the programmable delay line.
package delay_prog_pkg;

   // Registered output stage: a sample's result appears one clock after it is accepted.
   localparam int DELAY_LATENCY = 1;

   // Ceiling log2 for sizing address and counter fields.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result++;
      end
      return result;
   endfunction

endpackage

// File: rtl/delay_prog_bram_sdp.sv
// Simple dual-port RAM with one write port and one registered read port.
// The read register holds its value when i_rd_en is low.
module bram_sdp #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic              i_rd_en,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [DATA_W-1:0] o_rd_data
);

   logic [DATA_W-1:0] r_mem [2**ADDR_W];
   logic [DATA_W-1:0] r_rd_data;

   // Write on enable; registered read with hold.
   // NOTE: storage and read register have no reset, so the tools can map them onto block RAM;
   // stale contents are never flagged valid by the caller.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
      if (i_rd_en) begin
         r_rd_data <= r_mem[i_rd_addr];
      end
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/delay_prog.sv
// Runtime-programmable, multi-channel delay line counted in valid samples.
// A circular buffer holds past samples; delay 0 bypasses the buffer.
module delay_prog
   import delay_prog_pkg::*;
#(
   parameter  int DATA_WIDTH = 16,
   parameter  int N_CHANNELS = 4,
   parameter  int MAX_DELAY  = 1023,
   localparam int ADDR_WIDTH = clog2(MAX_DELAY + 1)
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [DATA_WIDTH*N_CHANNELS-1:0] din,
   input  logic                             din_valid,
   input  logic [ADDR_WIDTH-1:0]            delay_in,
   input  logic                             delay_load,
   output logic [DATA_WIDTH*N_CHANNELS-1:0] dout,
   output logic                             dout_valid,
   output logic                             delay_err
);

   localparam int                    DW    = DATA_WIDTH * N_CHANNELS;
   localparam logic [ADDR_WIDTH-1:0] MAX_D = ADDR_WIDTH'(MAX_DELAY);

   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_delay;
   logic [ADDR_WIDTH-1:0] r_fill;
   logic                  r_valid;
   logic                  r_err;
   logic                  r_bypass;
   logic [DW-1:0]         r_byp_data;

   logic                  w_over;
   logic [ADDR_WIDTH-1:0] w_load_delay;
   logic [ADDR_WIDTH-1:0] w_delay_eff;
   logic [ADDR_WIDTH-1:0] w_fill_prev;
   logic [ADDR_WIDTH-1:0] w_rd_addr;
   logic                  w_bypass;
   logic [DW-1:0]         w_ram_q;

   // A load in the same cycle as a sample takes effect for that sample, with an empty history.
   // NOTE: every output of this block is assigned unconditionally, so no latch can be inferred.
   always_comb begin
      w_over       = {1'b0, delay_in} > (ADDR_WIDTH + 1)'(MAX_DELAY);
      w_load_delay = w_over ? MAX_D : delay_in;
      w_delay_eff  = delay_load ? w_load_delay : r_delay;
      w_fill_prev  = delay_load ? '0 : r_fill;
      w_rd_addr    = r_wr_ptr - w_delay_eff;
      w_bypass     = (w_delay_eff == '0);
   end

   // Write pointer, active delay and saturating fill count.
   // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_delay  <= '0;
         r_fill   <= '0;
      end else begin
         if (din_valid) begin
            r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
         end
         if (delay_load) begin
            r_delay <= w_load_delay;
            r_fill  <= {{(ADDR_WIDTH-1){1'b0}}, din_valid};
         end else if (din_valid && (r_fill != MAX_D)) begin
            r_fill <= r_fill + ADDR_WIDTH'(1);
         end
      end
   end

   // Output qualifiers, error pulse and the bypass path; data holds through input gaps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid    <= 1'b0;
         r_err      <= 1'b0;
         r_bypass   <= 1'b1;
         r_byp_data <= '0;
      end else begin
         r_valid <= din_valid && (w_fill_prev >= w_delay_eff);
         r_err   <= delay_load && w_over;
         if (din_valid) begin
            r_bypass   <= w_bypass;
            r_byp_data <= din;
         end
      end
   end

   bram_sdp #(
      .DATA_W (DW),
      .ADDR_W (ADDR_WIDTH)
   ) u_bram (
      .clk       (clk),
      .i_wr_en   (din_valid),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (din),
      .i_rd_en   (din_valid),
      .i_rd_addr (w_rd_addr),
      .o_rd_data (w_ram_q)
   );

   // Reset selects the zeroed bypass register, so dout reads 0 immediately on reset.
   assign dout       = r_bypass ? r_byp_data : w_ram_q;
   assign dout_valid = r_valid;
   assign delay_err  = r_err;

endmodule

// File: tb/tb_delay_prog.sv
// Scoreboard bench for delay_prog: stimulus pushes expected outputs, a monitor pops and compares.
module tb_delay_prog;

   localparam int DATA_WIDTH = 16;
   localparam int N_CHANNELS = 4;
   localparam int MAX_DELAY  = 1023;
   localparam int AW         = 10;
   localparam int DW         = DATA_WIDTH * N_CHANNELS;
   localparam int MAX2       = 5;
   localparam int AW2        = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [DW-1:0] din;
   logic          din_valid;
   logic [AW-1:0] delay_in;
   logic          delay_load;
   logic [DW-1:0] dout;
   logic          dout_valid;
   logic          delay_err;

   logic [DW-1:0]  din2;
   logic           din_valid2;
   logic [AW2-1:0] delay_in2;
   logic           delay_load2;
   logic [DW-1:0]  dout2;
   logic           dout_valid2;
   logic           delay_err2;

   int            n_vec;
   int            n_err;
   int            m_seen;
   int            m_delay;
   int            m_fill;
   logic [DW-1:0] hist  [$];
   logic [DW-1:0] exp_q [$];

   always #5 clk = ~clk;

   delay_prog #(
      .DATA_WIDTH (DATA_WIDTH),
      .N_CHANNELS (N_CHANNELS),
      .MAX_DELAY  (MAX_DELAY)
   ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (din),
      .din_valid  (din_valid),
      .delay_in   (delay_in),
      .delay_load (delay_load),
      .dout       (dout),
      .dout_valid (dout_valid),
      .delay_err  (delay_err)
   );

   // Small-MAX_DELAY instance so an out-of-range request is representable on delay_in.
   delay_prog #(
      .DATA_WIDTH (DATA_WIDTH),
      .N_CHANNELS (N_CHANNELS),
      .MAX_DELAY  (MAX2)
   ) u_dut_err (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (din2),
      .din_valid  (din_valid2),
      .delay_in   (delay_in2),
      .delay_load (delay_load2),
      .dout       (dout2),
      .dout_valid (dout_valid2),
      .delay_err  (delay_err2)
   );

   function automatic logic [DW-1:0] word(input int n);
      logic [15:0] b;
      b = 16'(n);
      return {b ^ 16'hC000, b ^ 16'h8000, b ^ 16'h4000, b};
   endfunction

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   // Drive one cycle at the falling edge and predict the result from a sample-indexed history.
   task automatic send(input bit v, input logic [DW-1:0] d, input bit ld, input int dly);
      int idx;
      @(negedge clk);
      din        = d;
      din_valid  = v;
      delay_load = ld;
      delay_in   = dly[AW-1:0];
      if (ld) begin
         m_delay = (dly > MAX_DELAY) ? MAX_DELAY : dly;
         m_fill  = 0;
      end
      if (v) begin
         idx = hist.size();
         hist.push_back(d);
         if (m_fill >= m_delay) exp_q.push_back(hist[idx - m_delay]);
         if (m_fill < MAX_DELAY) m_fill++;
      end
      @(posedge clk);
   endtask

   task automatic drain(input string name);
      repeat (3) send(1'b0, '0, 1'b0, 0);
      check(name, DW'(exp_q.size()), '0);
   endtask

   initial begin
      int seen0;
      int nvalid;
      rst_n       = 1'b0;
      din         = '0;
      din_valid   = 1'b0;
      delay_in    = '0;
      delay_load  = 1'b0;
      din2        = '0;
      din_valid2  = 1'b0;
      delay_in2   = '0;
      delay_load2 = 1'b0;
      n_vec       = 0;
      n_err       = 0;
      m_seen      = 0;
      m_delay     = 0;
      m_fill      = 0;

      fork
         forever begin
            @(posedge clk);
            #1;
            if (dout_valid === 1'b1) begin
               m_seen++;
               if (exp_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL unexpected_valid: got dout=%h, required no valid output", dout);
               end else begin
                  check("dout", dout, exp_q.pop_front());
               end
            end
         end
      join_none

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset_dout", dout, '0);
      check("reset_valid", DW'(dout_valid), '0);
      check("reset_err", DW'(delay_err), '0);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: delay 5, continuous ramp
      seen0 = m_seen;
      send(1'b0, '0, 1'b1, 5);
      for (int n = 0; n < 40; n++) send(1'b1, word(n), 1'b0, 0);
      drain("t1_drain");
      check("t1_valid_count", DW'(m_seen - seen0), DW'(35));

      // 2: delay 0 bypass with random data and sparse valids
      seen0  = m_seen;
      nvalid = 0;
      send(1'b0, '0, 1'b1, 0);
      for (int n = 0; n < 40; n++) begin
         bit v;
         v = ($urandom_range(0, 3) != 0);
         if (v) nvalid++;
         send(v, {$urandom, $urandom}, 1'b0, 0);
      end
      drain("t2_drain");
      check("t2_valid_count", DW'(m_seen - seen0), DW'(nvalid));

      // 3: maximum delay across pointer wrap
      seen0 = m_seen;
      send(1'b0, '0, 1'b1, MAX_DELAY);
      #1;
      check("t3_no_err_at_max", DW'(delay_err), '0);
      for (int n = 0; n < 3000; n++) send(1'b1, word(n), 1'b0, 0);
      drain("t3_drain");
      check("t3_valid_count", DW'(m_seen - seen0), DW'(1977));

      // 4: delay 3 with random gaps
      seen0  = m_seen;
      nvalid = 0;
      send(1'b0, '0, 1'b1, 3);
      for (int n = 0; n < 60; n++) begin
         bit v;
         v = ($urandom_range(0, 1) != 0);
         if (v) nvalid++;
         send(v, word(5000 + n), 1'b0, 0);
      end
      drain("t4_drain");
      check("t4_valid_count", DW'(m_seen - seen0), DW'(nvalid - 3));

      // 5: reload 10 -> 4 with a sample in the load cycle
      seen0 = m_seen;
      send(1'b0, '0, 1'b1, 10);
      for (int n = 0; n < 30; n++) send(1'b1, word(7000 + n), 1'b0, 0);
      send(1'b1, word(7030), 1'b1, 4);
      for (int n = 31; n < 51; n++) send(1'b1, word(7000 + n), 1'b0, 0);
      drain("t5_drain");
      check("t5_valid_count", DW'(m_seen - seen0), DW'(37));

      // 5b: out-of-range request saturates and pulses delay_err (MAX_DELAY=5 instance)
      @(negedge clk);
      din2        = word(0);
      din_valid2  = 1'b1;
      delay_in2   = 3'd7;
      delay_load2 = 1'b1;
      @(posedge clk);
      #1;
      check("err_pulse", DW'(delay_err2), DW'(1));
      check("err_load_sample_valid", DW'(dout_valid2), '0);
      for (int k = 1; k < 10; k++) begin
         @(negedge clk);
         din2        = word(k);
         delay_load2 = 1'b0;
         @(posedge clk);
         #1;
         if (k == 1) check("err_one_cycle", DW'(delay_err2), '0);
         check("sat_valid", DW'(dout_valid2), DW'(k >= MAX2));
         if (k >= MAX2) check("sat_dout", dout2, word(k - MAX2));
      end
      @(negedge clk);
      din_valid2 = 1'b0;

      // 6: reset mid-stream, then bypass
      send(1'b0, '0, 1'b1, 3);
      for (int n = 0; n < 10; n++) send(1'b1, word(9000 + n), 1'b0, 0);
      @(negedge clk);
      din_valid = 1'b0;
      rst_n     = 1'b0;
      #1;
      check("rst_mid_dout", dout, '0);
      check("rst_mid_valid", DW'(dout_valid), '0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n   = 1'b1;
      m_delay = 0;
      m_fill  = 0;
      hist.delete();
      exp_q.delete();
      seen0 = m_seen;
      for (int n = 0; n < 10; n++) send(1'b1, word(9500 + n), 1'b0, 0);
      drain("t6_drain");
      check("t6_valid_count", DW'(m_seen - seen0), DW'(10));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
